// File: rtl/iic_pkg.sv
// Shared constants and state encoding for the I2C target.
package iic_pkg;

    localparam int unsigned IIC_BYTE_W = 8;
    localparam logic        IIC_ACK    = 1'b0;
    localparam logic        IIC_NACK   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } iic_state_e;

endpackage

// File: rtl/iic_edge_detect.sv
// Synchronizes the SCL/SDA pads and flags SCL edges plus START/STOP conditions.
module iic_edge_detect #(
    parameter int unsigned C_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_pad,
    input  logic sda_pad,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [C_SYNC_STAGES-1:0] scl_sync;
    logic [C_SYNC_STAGES-1:0] sda_sync;
    logic                     scl_d;
    logic                     sda_d;
    logic                     scl_s;

    // Idle bus level is high, so the chain resets to 1 to avoid a false START.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[C_SYNC_STAGES-2:0], scl_pad};
            sda_sync <= {sda_sync[C_SYNC_STAGES-2:0], sda_pad};
            scl_d    <= scl_sync[C_SYNC_STAGES-1];
            sda_d    <= sda_sync[C_SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[C_SYNC_STAGES-1];
    assign sda_s     = sda_sync[C_SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/iic_target.sv
// I2C target with register-pointer addressing and auto-incrementing
// write/read data, exposed as a simple strobe-based register port.
module iic_target
    import iic_pkg::*;
#(
    parameter logic [6:0]  C_I2C_SLAVE_ADDR = 7'b1110110,
    parameter int unsigned C_SYNC_STAGES    = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  SCL_I,
    input  logic                  SDA_I,
    output logic                  SCL_T,
    output logic                  SDA_T,
    output logic [IIC_BYTE_W-1:0] Reg_Addr,
    output logic [IIC_BYTE_W-1:0] Reg_Wdata,
    output logic                  Reg_We,
    input  logic [IIC_BYTE_W-1:0] Reg_Rdata,
    output logic                  Reg_Re,
    output logic                  Busy
);

    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start_det;
    logic                  stop_det;
    logic                  sda_s;
    iic_state_e            state;
    logic [2:0]            bit_cnt;
    logic [IIC_BYTE_W-1:0] shreg;
    logic                  byte_done;
    logic                  mack;
    logic                  rw;

    iic_edge_detect #(
        .C_SYNC_STAGES(C_SYNC_STAGES)
    ) u_edge (
        .clk      (Clk),
        .rst      (Rst),
        .scl_pad  (SCL_I),
        .sda_pad  (SDA_I),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    assign SCL_T = 1'b1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            mack      <= 1'b0;
            rw        <= 1'b0;
            SDA_T     <= 1'b1;
            Reg_Addr  <= '0;
            Reg_Wdata <= '0;
            Reg_We    <= 1'b0;
            Reg_Re    <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            Reg_We <= 1'b0;
            Reg_Re <= 1'b0;
            // Pointer advances the cycle after the write strobe so the strobe sees the target address.
            if (Reg_We)
                Reg_Addr <= Reg_Addr + 1'b1;

            if (start_det) begin
                state     <= ST_ADDR;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                mack      <= 1'b0;
                SDA_T     <= 1'b1;
            end else if (stop_det) begin
                state <= ST_IDLE;
                SDA_T <= 1'b1;
                Busy  <= 1'b0;
            end else begin
                if (scl_rise) begin
                    case (state)
                        ST_ADDR, ST_PTR, ST_WDATA: begin
                            shreg   <= {shreg[IIC_BYTE_W-2:0], sda_s};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7)
                                byte_done <= 1'b1;
                        end
                        ST_RDATA: begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7)
                                byte_done <= 1'b1;
                        end
                        ST_RDATA_ACK: begin
                            if (sda_s == IIC_ACK) begin
                                Reg_Addr <= Reg_Addr + 1'b1;
                                mack     <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                        default: ;
                    endcase
                end

                if (scl_fall) begin
                    case (state)
                        ST_ADDR: if (byte_done) begin
                            byte_done <= 1'b0;
                            if (shreg[7:1] == C_I2C_SLAVE_ADDR) begin
                                SDA_T <= IIC_ACK;
                                Busy  <= 1'b1;
                                rw    <= shreg[0];
                                state <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                        ST_ADDR_ACK: begin
                            if (rw) begin
                                shreg  <= Reg_Rdata;
                                Reg_Re <= 1'b1;
                                SDA_T  <= Reg_Rdata[IIC_BYTE_W-1];
                                state  <= ST_RDATA;
                            end else begin
                                SDA_T <= 1'b1;
                                state <= ST_PTR;
                            end
                        end
                        ST_PTR: if (byte_done) begin
                            byte_done <= 1'b0;
                            Reg_Addr  <= shreg;
                            SDA_T     <= IIC_ACK;
                            state     <= ST_PTR_ACK;
                        end
                        ST_WDATA: if (byte_done) begin
                            byte_done <= 1'b0;
                            Reg_Wdata <= shreg;
                            Reg_We    <= 1'b1;
                            SDA_T     <= IIC_ACK;
                            state     <= ST_WDATA_ACK;
                        end
                        ST_PTR_ACK, ST_WDATA_ACK: begin
                            SDA_T <= 1'b1;
                            state <= ST_WDATA;
                        end
                        ST_RDATA: begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                mack      <= 1'b0;
                                SDA_T     <= 1'b1;
                                state     <= ST_RDATA_ACK;
                            end else begin
                                shreg <= {shreg[IIC_BYTE_W-2:0], 1'b0};
                                SDA_T <= shreg[IIC_BYTE_W-2];
                            end
                        end
                        ST_RDATA_ACK: if (mack) begin
                            mack   <= 1'b0;
                            shreg  <= Reg_Rdata;
                            Reg_Re <= 1'b1;
                            SDA_T  <= Reg_Rdata[IIC_BYTE_W-1];
                            state  <= ST_RDATA;
                        end
                        default: SDA_T <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule
